seg_key_history_ctrl: RTL and testbench

- Sits downstream of the keyboard input decoder, which outputs a 4-bit key code: 0 W, 1 A, 2 S, 3 D, 4 Up, 5 Right, 6 Left, 7 Down, 8 Enter, 9 F, 10 R, 11 T, 12 none.
- Qualifies each new key press and pushes it into a 4-deep history.
- Time-multiplexes the history onto the Basys3 4-digit seven-segment display.
- Exactly one history entry per physical press, regardless of how long the key is held.

---
 rtl/seg_key_pkg.sv | 44 ++++
 rtl/seg_glyph_decode.sv | 20 ++
 rtl/seg_key_history_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_seg_key_history_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_key_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_key_pkg
//  Purpose  : Shared constants, capture FSM state type and seven-segment glyph
//             table for the key history display block.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package seg_key_pkg;

   localparam logic [3:0] KEY_NONE   = 4'd12;
   localparam logic [3:0] HIST_BLANK = 4'hF;
   localparam int         NUM_DIGITS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      QUAL = 2'd1,
      HELD = 2'd2
   } cap_state_e;

   // Active-low patterns, bit 0 = segment a ... bit 6 = segment g.
   // Packed so that GLYPH_TABLE[code] selects the entry for that code;
   // entries are listed from code 15 down to code 0.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'h7F,  // 15 blank
      7'h7F,  // 14 blank
      7'h7F,  // 13 blank
      7'h7F,  // 12 blank (no key)
      7'h07,  // 11 t
      7'h2F,  // 10 r
      7'h0E,  //  9 F
      7'h06,  //  8 E (Enter)
      7'h77,  //  7 Down
      7'h4F,  //  6 Left
      7'h79,  //  5 Right
      7'h7E,  //  4 Up
      7'h21,  //  3 d
      7'h12,  //  2 S
      7'h08,  //  1 A
      7'h41   //  0 W
   };

endpackage : seg_key_pkg
`default_nettype wire

// File: rtl/seg_glyph_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg_glyph_decode
//  Purpose  : Combinational 4-bit key/history code to active-low seven-segment
//             pattern lookup.
//  Ports    : code - 4-bit history entry code
//             seg  - 7-bit active-low segments (seg[0]=a .. seg[6]=g)
//  Revision : 1.0  initial release
// ============================================================================
module seg_glyph_decode
   import seg_key_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = GLYPH_TABLE[code];

endmodule : seg_glyph_decode
`default_nettype wire

// File: rtl/seg_key_history_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_key_history_ctrl
//  Purpose  : Qualifies key presses from the keyboard decoder, keeps a 4-deep
//             history of accepted keys and scans it onto a 4-digit seven-
//             segment display.
//  Ports    : clk           - system clock
//             rst           - synchronous active-high reset
//             key_code      - decoded key code, 12..15 = no key
//             clear         - one-cycle pulse, empties the history
//             an            - digit anodes, active-low, an[0] rightmost
//             seg           - segments, active-low, seg[0]=a .. seg[6]=g
//             dp            - decimal point, active-low (marks newest entry)
//             new_key       - one-cycle pulse after a key is accepted
//             history_count - number of valid entries, 0..4
//  Revision : 1.0  initial release
// ============================================================================
module seg_key_history_ctrl
   import seg_key_pkg::*;
#(
   parameter int REFRESH_DIV   = 100000,
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_code,
   input  logic       clear,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       new_key,
   output logic [2:0] history_count
);

   localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam int REF_W = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);

   localparam logic [CNT_W-1:0] c_cnt_target = CNT_W'(STABLE_CYCLES);
   localparam logic [REF_W-1:0] c_ref_last   = REF_W'(REFRESH_DIV - 1);

   // ------------------------------------------------------------------
   // Capture FSM
   // ------------------------------------------------------------------
   cap_state_e       r_state, w_state_nxt;
   logic [3:0]       r_cand,  w_cand_nxt;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_valid;
   logic             w_accept;

   assign w_valid   = (key_code < KEY_NONE);
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cand  <= HIST_BLANK;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cand  <= w_cand_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_cand_nxt  = key_code;
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = (STABLE_CYCLES <= 1) ? HELD : QUAL;
            end
         end
         QUAL: begin
            if (key_code == r_cand) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == c_cnt_target) begin
                  w_state_nxt = HELD;
               end
            end else if (w_valid) begin
               // A different key restarts qualification on the new code.
               w_cand_nxt = key_code;
               w_cnt_nxt  = CNT_W'(1);
            end else begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end
         end
         HELD: begin
            // Only a release re-arms capture; code changes are ignored here.
            if (!w_valid) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Output logic: accept strobe for the history shifter
   always_comb begin
      w_accept = 1'b0;
      case (r_state)
         IDLE:    w_accept = w_valid && (STABLE_CYCLES <= 1);
         QUAL:    w_accept = (key_code == r_cand) && (w_cnt_inc == c_cnt_target);
         default: w_accept = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // History shift register
   // ------------------------------------------------------------------
   logic [3:0] r_hist [NUM_DIGITS];

   // On accept key_code equals the candidate (or is the first sample when a
   // single stable cycle suffices), so it is pushed directly.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_hist[i] <= HIST_BLANK;
         end
         history_count <= 3'd0;
         new_key       <= 1'b0;
      end else if (w_accept) begin
         for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            r_hist[i] <= r_hist[i-1];
         end
         r_hist[0] <= key_code;
         if (history_count < 3'(NUM_DIGITS)) begin
            history_count <= history_count + 3'd1;
         end
         new_key <= 1'b1;
      end else begin
         new_key <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Display scan
   // ------------------------------------------------------------------
   logic [REF_W-1:0] r_refresh;
   logic [1:0]       r_idx;
   logic [6:0]       w_glyph;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_refresh <= '0;
         r_idx     <= 2'd0;
      end else if (r_refresh == c_ref_last) begin
         r_refresh <= '0;
         r_idx     <= r_idx + 2'd1;
      end else begin
         r_refresh <= r_refresh + REF_W'(1);
      end
   end

   seg_glyph_decode u_glyph (
      .code (r_hist[r_idx]),
      .seg  (w_glyph)
   );

   // Registered drive of the display pins from the current scan index.
   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= 4'hF;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= ~(4'b0001 << r_idx);
         seg <= w_glyph;
         dp  <= ~((r_idx == 2'd0) && (history_count != 3'd0));
      end
   end

endmodule : seg_key_history_ctrl
`default_nettype wire

// File: tb/tb_seg_key_history_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_key_history_ctrl
//  Purpose  : Directed self-checking bench for seg_key_history_ctrl with
//             REFRESH_DIV=4, STABLE_CYCLES=3.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_key_history_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_code;
   logic       clear;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       new_key;
   logic [2:0] history_count;

   int total = 0;
   int bad   = 0;
   int pulses;

   logic [6:0] dig_seg [4];
   logic       dig_dp  [4];

   always #5 clk = ~clk;

   seg_key_history_ctrl #(
      .REFRESH_DIV   (4),
      .STABLE_CYCLES (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .key_code      (key_code),
      .clear         (clear),
      .an            (an),
      .seg           (seg),
      .dp            (dp),
      .new_key       (new_key),
      .history_count (history_count)
   );

   // One clock edge, then settle; also counts new_key pulses seen.
   task automatic tick();
      @(posedge clk);
      #1;
      if (new_key === 1'b1) pulses++;
   endtask

   task automatic press(input logic [3:0] k);
      key_code = k;
      repeat (3) tick();
      key_code = 4'd12;
      tick();
   endtask

   // Captures one full scan starting at the first cycle of digit 0,
   // checking that each anode pattern is held for exactly 4 cycles.
   task automatic read_digits(input string tag);
      int n;
      n = 0;
      while (an !== 4'b0111 && n < 64) begin tick(); n++; end
      while (an !== 4'b1110 && n < 64) begin tick(); n++; end
      total++;
      if (n >= 64) begin
         bad++;
         $display("FAIL %s scan_sync: an=%b never reached digit 0", tag, an);
         return;
      end
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
               dig_seg[d] = seg;
               dig_dp[d]  = dp;
               total++;
               if (an !== ~(4'b0001 << d)) begin
                  bad++;
                  $display("FAIL %s an_digit%0d: got %b want %b", tag, d, an, ~(4'b0001 << d));
               end
            end else if (c == 3) begin
               total++;
               if (an !== ~(4'b0001 << d)) begin
                  bad++;
                  $display("FAIL %s an_hold%0d: got %b want %b", tag, d, an, ~(4'b0001 << d));
               end
            end
            tick();
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; key_code = 4'd1;
      pulses = 0;
      repeat (2) tick();
      total++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
         bad++;
         $display("FAIL reset_display: an=%h seg=%h dp=%b want F 7F 1", an, seg, dp);
      end
      total++;
      if (new_key !== 1'b0 || history_count !== 3'd0 || pulses != 0) begin
         bad++;
         $display("FAIL reset_state: new_key=%b count=%0d pulses=%0d want 0 0 0",
                  new_key, history_count, pulses);
      end
      key_code = 4'd12;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_accept();
      pulses = 0;
      key_code = 4'd1;
      tick(); tick();
      total++;
      if (new_key !== 1'b0) begin
         bad++;
         $display("FAIL basic_early: new_key=%b want 0 after 2 edges", new_key);
      end
      tick();
      total++;
      if (new_key !== 1'b1 || history_count !== 3'd1) begin
         bad++;
         $display("FAIL basic_accept: new_key=%b count=%0d want 1 1", new_key, history_count);
      end
      key_code = 4'd12;
      tick();
      total++;
      if (new_key !== 1'b0 || pulses != 1) begin
         bad++;
         $display("FAIL basic_pulse_width: new_key=%b pulses=%0d want 0 1", new_key, pulses);
      end
      read_digits("basic");
      total++;
      if (dig_seg[0] !== 7'h08 || dig_dp[0] !== 1'b0 || dig_seg[1] !== 7'h7F || dig_dp[1] !== 1'b1) begin
         bad++;
         $display("FAIL basic_digit: seg0=%h dp0=%b seg1=%h dp1=%b want 08 0 7F 1",
                  dig_seg[0], dig_dp[0], dig_seg[1], dig_dp[1]);
      end
   endtask

   task automatic test_glitch_reject();
      clear = 1'b1; tick(); clear = 1'b0;
      pulses = 0;
      key_code = 4'd9; tick(); tick();
      key_code = 4'd12; tick(); tick();
      total++;
      if (pulses != 0 || history_count !== 3'd0) begin
         bad++;
         $display("FAIL glitch_short: pulses=%0d count=%0d want 0 0", pulses, history_count);
      end
      key_code = 4'd9; tick(); tick();
      key_code = 4'd8; tick(); tick(); tick();
      key_code = 4'd12; tick();
      total++;
      if (pulses != 1 || history_count !== 3'd1) begin
         bad++;
         $display("FAIL glitch_switch: pulses=%0d count=%0d want 1 1", pulses, history_count);
      end
      read_digits("glitch");
      total++;
      if (dig_seg[0] !== 7'h06) begin
         bad++;
         $display("FAIL glitch_digit: seg0=%h want 06", dig_seg[0]);
      end
   endtask

   task automatic test_hold_repeat();
      clear = 1'b1; tick(); clear = 1'b0;
      pulses = 0;
      key_code = 4'd8;
      repeat (20) tick();
      total++;
      if (pulses != 1 || history_count !== 3'd1) begin
         bad++;
         $display("FAIL hold_single: pulses=%0d count=%0d want 1 1", pulses, history_count);
      end
      key_code = 4'd12; tick(); tick();
      key_code = 4'd8; tick(); tick(); tick();
      key_code = 4'd12; tick();
      total++;
      if (pulses != 2 || history_count !== 3'd2) begin
         bad++;
         $display("FAIL hold_repeat: pulses=%0d count=%0d want 2 2", pulses, history_count);
      end
      read_digits("hold");
      total++;
      if (dig_seg[0] !== 7'h06 || dig_seg[1] !== 7'h06 || dig_seg[2] !== 7'h7F) begin
         bad++;
         $display("FAIL hold_digits: %h %h %h want 06 06 7F", dig_seg[0], dig_seg[1], dig_seg[2]);
      end
   endtask

   task automatic test_overflow();
      clear = 1'b1; tick(); clear = 1'b0;
      pulses = 0;
      press(4'd0); press(4'd1); press(4'd2); press(4'd3); press(4'd9);
      total++;
      if (pulses != 5 || history_count !== 3'd4) begin
         bad++;
         $display("FAIL overflow_count: pulses=%0d count=%0d want 5 4", pulses, history_count);
      end
      read_digits("overflow");
      total++;
      if (dig_seg[0] !== 7'h0E || dig_seg[1] !== 7'h21 || dig_seg[2] !== 7'h12 || dig_seg[3] !== 7'h08) begin
         bad++;
         $display("FAIL overflow_digits: %h %h %h %h want 0E 21 12 08",
                  dig_seg[0], dig_seg[1], dig_seg[2], dig_seg[3]);
      end
      total++;
      if (dig_dp[0] !== 1'b0 || dig_dp[1] !== 1'b1 || dig_dp[2] !== 1'b1 || dig_dp[3] !== 1'b1) begin
         bad++;
         $display("FAIL overflow_dp: %b%b%b%b want 0111", dig_dp[0], dig_dp[1], dig_dp[2], dig_dp[3]);
      end
   endtask

   task automatic test_clear_collision();
      pulses = 0;
      key_code = 4'd2;
      tick(); tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      total++;
      if (new_key !== 1'b0 || history_count !== 3'd0) begin
         bad++;
         $display("FAIL collide_accept: new_key=%b count=%0d want 0 0", new_key, history_count);
      end
      repeat (10) tick();
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL collide_held: pulses=%0d want 0", pulses);
      end
      read_digits("collide");
      total++;
      if (dig_seg[0] !== 7'h7F || dig_seg[1] !== 7'h7F || dig_seg[2] !== 7'h7F ||
          dig_seg[3] !== 7'h7F || dig_dp[0] !== 1'b1) begin
         bad++;
         $display("FAIL collide_blank: %h %h %h %h dp0=%b want 7F x4 dp 1",
                  dig_seg[0], dig_seg[1], dig_seg[2], dig_seg[3], dig_dp[0]);
      end
      key_code = 4'd12; tick();
      press(4'd2);
      total++;
      if (pulses != 1 || history_count !== 3'd1) begin
         bad++;
         $display("FAIL collide_repress: pulses=%0d count=%0d want 1 1", pulses, history_count);
      end
   endtask

   task automatic test_reset_midqual();
      pulses = 0;
      key_code = 4'd5;
      tick(); tick();
      rst = 1'b1;
      tick();
      total++;
      if (new_key !== 1'b0 || history_count !== 3'd0 || an !== 4'hF) begin
         bad++;
         $display("FAIL midqual_reset: new_key=%b count=%0d an=%h want 0 0 F",
                  new_key, history_count, an);
      end
      rst = 1'b0;
      tick();
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL midqual_restart: pulses=%0d want 0", pulses);
      end
      tick(); tick();
      total++;
      if (pulses != 1 || history_count !== 3'd1) begin
         bad++;
         $display("FAIL midqual_requal: pulses=%0d count=%0d want 1 1", pulses, history_count);
      end
      key_code = 4'd12; tick();
   endtask

   initial begin
      test_reset();
      test_basic_accept();
      test_glitch_reject();
      test_hold_repeat();
      test_overflow();
      test_clear_collision();
      test_reset_midqual();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_seg_key_history_ctrl
`default_nettype wire
